// File: rtl/register_file_param.sv
// Parametrised register file: two combinational read ports, one synchronous
// write port, optional zero register / write bypass, and a bulk-clear sweep.
module register_file_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] wd,
    input  logic              clr_req,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy,
    output logic              clr_done,
    output logic              wr_drop
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;
    logic              clr_done_nxt;
    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_en;
    logic              byp1, byp2;
    logic              zero1, zero2;

    assign busy  = (state == CLEAR);
    // Writes to the hardwired zero register vanish without raising wr_drop.
    assign wr_en = we && !busy && !((ZERO_REG != 0) && (A3 == '0));

    assign zero1 = (ZERO_REG != 0) && (A1 == '0);
    assign zero2 = (ZERO_REG != 0) && (A2 == '0);
    assign byp1  = (BYPASS != 0) && wr_en && (A1 == A3);
    assign byp2  = (BYPASS != 0) && wr_en && (A2 == A3);

    assign rd1 = byp1 ? wd : (zero1 ? '0 : regs[A1]);
    assign rd2 = byp2 ? wd : (zero2 ? '0 : regs[A2]);

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        clr_done_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    idx_nxt   = '0;
                end
            end
            CLEAR: begin
                idx_nxt = idx + ADDR_W'(1);
                if (idx == ADDR_W'(DEPTH - 1)) begin
                    state_nxt    = IDLE;
                    clr_done_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            idx      <= '0;
            clr_done <= 1'b0;
            wr_drop  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            clr_done <= clr_done_nxt;
            wr_drop  <= we && busy;
            // The sweep owns the write port while busy; ordinary writes are dropped.
            if (busy) begin
                regs[idx] <= '0;
            end else if (wr_en) begin
                regs[A3] <= wd;
            end
        end
    end

endmodule

// File: tb/tb_register_file_param.sv
// Scoreboard bench: two register files (plain, and zero-reg+bypass) driven in
// parallel and checked every cycle against an array-based reference model.
module tb_register_file_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  A1 = '0, A2 = '0, A3 = '0;
    logic [15:0] wd = '0;
    logic        clr_req = 1'b0;

    logic [15:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic        busy_a, done_a, drop_a, busy_b, done_b, drop_b;

    register_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0)) dut (
        .clk(clk), .rst(rst), .we(we), .A1(A1), .A2(A2), .A3(A3), .wd(wd),
        .clr_req(clr_req), .rd1(rd1_a), .rd2(rd2_a), .busy(busy_a),
        .clr_done(done_a), .wr_drop(drop_a));

    register_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) dut_bz (
        .clk(clk), .rst(rst), .we(we), .A1(A1), .A2(A2), .A3(A3), .wd(wd),
        .clr_req(clr_req), .rd1(rd1_b), .rd2(rd2_b), .busy(busy_b),
        .clr_done(done_b), .wr_drop(drop_b));

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rd1_a, rd2_a, rd1_b, rd2_b;
        logic        busy, done, drop;
    } exp_t;

    exp_t sbq[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model state
    logic [15:0] mem_a [16];
    logic [15:0] mem_b [16];
    bit          m_busy, m_done, m_drop;
    int          m_pos;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        m_busy = 0; m_done = 0; m_drop = 0; m_pos = 0;
    endfunction

    function automatic exp_t model_outputs();
        exp_t e;
        bit   wr_b;
        wr_b    = we && !m_busy && (A3 != 0);
        e.rd1_a = mem_a[A1];
        e.rd2_a = mem_a[A2];
        e.rd1_b = (wr_b && A1 == A3) ? wd : ((A1 == 0) ? 16'h0 : mem_b[A1]);
        e.rd2_b = (wr_b && A2 == A3) ? wd : ((A2 == 0) ? 16'h0 : mem_b[A2]);
        e.busy  = m_busy;
        e.done  = m_done;
        e.drop  = m_drop;
        return e;
    endfunction

    function automatic void model_advance();
        m_drop = we && m_busy;
        m_done = 0;
        if (m_busy) begin
            mem_a[m_pos] = '0;
            mem_b[m_pos] = '0;
            m_pos++;
            if (m_pos == 16) begin
                m_busy = 0;
                m_done = 1;
                m_pos  = 0;
            end
        end else begin
            if (we) mem_a[A3] = wd;
            if (we && A3 != 0) mem_b[A3] = wd;
            if (clr_req) begin
                m_busy = 1;
                m_pos  = 0;
            end
        end
    endfunction

    task automatic step(input logic w, input logic [3:0] a1, input logic [3:0] a2,
                        input logic [3:0] a3, input logic [15:0] d,
                        input logic c, input logic r);
        @(negedge clk);
        we = w; A1 = a1; A2 = a2; A3 = a3; wd = d; clr_req = c; rst = r;
        if (!r) model_reset();
        sbq.push_back(model_outputs());
        if (r) model_advance();
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: every cycle the DUTs present settled outputs; pop and compare.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("rd1_a", rd1_a, e.rd1_a);
            chk("rd2_a", rd2_a, e.rd2_a);
            chk("rd1_b", rd1_b, e.rd1_b);
            chk("rd2_b", rd2_b, e.rd2_b);
            chk("busy_a", {15'b0, busy_a}, {15'b0, e.busy});
            chk("busy_b", {15'b0, busy_b}, {15'b0, e.busy});
            chk("clr_done_a", {15'b0, done_a}, {15'b0, e.done});
            chk("clr_done_b", {15'b0, done_b}, {15'b0, e.done});
            chk("wr_drop_a", {15'b0, drop_a}, {15'b0, e.drop});
            chk("wr_drop_b", {15'b0, drop_b}, {15'b0, e.drop});
        end
    end

    task automatic fill();
        for (int i = 0; i < 16; i++) step(1, 4'(i), 4'(15 - i), 4'(i), 16'(i + 1), 0, 1);
    endtask

    initial begin
        model_reset();
        // Reset held, then released; r4/r5 read 0 before writes
        repeat (3) step(0, 4, 5, 0, 16'h0, 0, 0);
        step(0, 4, 5, 0, 16'h0, 0, 1);
        step(1, 4, 5, 4, 16'd45, 0, 1);
        step(1, 4, 5, 5, 16'd67, 0, 1);
        step(0, 4, 5, 0, 16'h0, 0, 1);
        // Same-cycle bypass on r7, then normal read
        step(1, 7, 7, 7, 16'hBEEF, 0, 1);
        step(0, 7, 4, 0, 16'h0, 0, 1);
        // Write to r0: zero register discards it, plain file stores it
        step(1, 0, 0, 0, 16'h1234, 0, 1);
        step(0, 0, 0, 0, 16'h0, 0, 1);
        // Full fill, then sweep with mid-sweep reads, dropped write, ignored clr_req
        fill();
        step(0, 3, 12, 0, 16'h0, 1, 1);
        for (int k = 1; k <= 16; k++) begin
            step(k == 6, 3, 12, 9, 16'd99, k == 8, 1);
        end
        for (int i = 0; i < 16; i++) step(0, 4'(i), 9, 0, 16'h0, 0, 1);
        // Write and clr_req in the same idle cycle
        step(1, 6, 6, 6, 16'h5A5A, 1, 1);
        for (int k = 0; k < 18; k++) step(0, 6, 4'(k), 0, 16'h0, 0, 1);
        // Reset at sweep cycle 5 aborts it; a later write works normally
        fill();
        step(0, 3, 12, 0, 16'h0, 1, 1);
        for (int k = 1; k <= 4; k++) step(0, 3, 12, 0, 16'h0, 0, 1);
        step(0, 12, 15, 0, 16'h0, 0, 0);
        step(0, 12, 15, 0, 16'h0, 0, 1);
        step(1, 2, 12, 2, 16'd5, 0, 1);
        step(0, 2, 15, 0, 16'h0, 0, 1);
        step(0, 12, 15, 0, 16'h0, 0, 1);
        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 4'($urandom),
                 16'($urandom), $urandom_range(0, 24) == 0, $urandom_range(0, 199) != 0);
        end
        step(0, 0, 0, 0, 16'h0, 0, 1);
        @(negedge clk);
        @(negedge clk);
        #3;
        if (sbq.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
